// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, port IDs,
// grant encodings and the default access timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational two-way round-robin pick. On a tie the port that did not win
// last time is chosen; a lone requester always wins.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  port_id_t   last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot winner selection with the tie broken against last_grant.
    always_comb begin
        grant_o = GRANT_NONE;
        if (req_a_i && req_b_i) begin
            grant_o = (last_grant_i == PORT_B) ? GRANT_A : GRANT_B;
        end else if (req_a_i) begin
            grant_o = GRANT_A;
        end else if (req_b_i) begin
            grant_o = GRANT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single MemoryInterface. Accesses are
// serialised IDLE -> ACCESS -> RESP -> RELEASE with round-robin fairness, a
// one-cycle MFC pulse to the owner and a timeout for hung memory accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A_Address,
    input  logic [DATA_W-1:0] A_Data_In,
    input  logic              A_Read,
    input  logic              A_Write,
    output logic [DATA_W-1:0] A_Data_Out,
    output logic              A_MFC,
    output logic              A_ANA_FLAG,
    input  logic [ADDR_W-1:0] B_Address,
    input  logic [DATA_W-1:0] B_Data_In,
    input  logic              B_Read,
    input  logic              B_Write,
    output logic [DATA_W-1:0] B_Data_Out,
    output logic              B_MFC,
    output logic              B_ANA_FLAG,
    output logic [ADDR_W-1:0] MEM_Address,
    output logic [DATA_W-1:0] MEM_Data_In,
    output logic              MEM_Read,
    output logic              MEM_Write,
    input  logic [DATA_W-1:0] MEM_Data_Out,
    input  logic              MEM_MFC,
    input  logic              MEM_ANA_FLAG,
    output logic [1:0]        Grant,
    output logic              Timeout_Flag
);

    // Counter only needs to reach TIMEOUT_CYCLES-1 before the forced exit.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] a_dout_q, a_dout_d;
    logic              a_ana_q, a_ana_d;
    logic              a_mfc_q, a_mfc_d;
    logic [DATA_W-1:0] b_dout_q, b_dout_d;
    logic              b_ana_q, b_ana_d;
    logic              b_mfc_q, b_mfc_d;
    logic              tmo_q, tmo_d;

    logic              req_a, req_b;
    logic [1:0]        pick;
    logic              owner_b;

    assign req_a   = A_Read | A_Write;
    assign req_b   = B_Read | B_Write;
    assign owner_b = (grant_q == GRANT_B);

    mem_arb_rr2 u_rr2 (
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );

    // Next-state, grant, strobe and response-register logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        a_dout_d     = a_dout_q;
        a_ana_d      = a_ana_q;
        a_mfc_d      = 1'b0;
        b_dout_d     = b_dout_q;
        b_ana_d      = b_ana_q;
        b_mfc_d      = 1'b0;
        tmo_d        = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick == GRANT_A) begin
                    grant_d      = GRANT_A;
                    last_grant_d = PORT_A;
                    mem_addr_d   = A_Address;
                    mem_wdata_d  = A_Data_In;
                    // Write wins when a requester raises both strobes.
                    mem_wr_d     = A_Write;
                    mem_rd_d     = ~A_Write;
                    state_d      = ST_ACCESS;
                end else if (pick == GRANT_B) begin
                    grant_d      = GRANT_B;
                    last_grant_d = PORT_B;
                    mem_addr_d   = B_Address;
                    mem_wdata_d  = B_Data_In;
                    mem_wr_d     = B_Write;
                    mem_rd_d     = ~B_Write;
                    state_d      = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_ONE;
                if (MEM_MFC) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = ST_RESP;
                    if (owner_b) begin
                        if (!mem_wr_q) b_dout_d = MEM_Data_Out;
                        b_ana_d = MEM_ANA_FLAG;
                        b_mfc_d = 1'b1;
                    end else begin
                        if (!mem_wr_q) a_dout_d = MEM_Data_Out;
                        a_ana_d = MEM_ANA_FLAG;
                        a_mfc_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Memory never answered: complete with an error response.
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    tmo_d    = 1'b1;
                    state_d  = ST_RESP;
                    if (owner_b) begin
                        b_dout_d = '0;
                        b_ana_d  = 1'b1;
                        b_mfc_d  = 1'b1;
                    end else begin
                        a_dout_d = '0;
                        a_ana_d  = 1'b1;
                        a_mfc_d  = 1'b1;
                    end
                end
            end

            ST_RESP: begin
                grant_d = GRANT_NONE;
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                cnt_d = '0;
                // Wait for memory to drop MFC so it cannot complete the next access early.
                if (!MEM_MFC) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_B;
            cnt_q        <= '0;
            grant_q      <= GRANT_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            a_dout_q     <= '0;
            a_ana_q      <= 1'b0;
            a_mfc_q      <= 1'b0;
            b_dout_q     <= '0;
            b_ana_q      <= 1'b0;
            b_mfc_q      <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            a_dout_q     <= a_dout_d;
            a_ana_q      <= a_ana_d;
            a_mfc_q      <= a_mfc_d;
            b_dout_q     <= b_dout_d;
            b_ana_q      <= b_ana_d;
            b_mfc_q      <= b_mfc_d;
            tmo_q        <= tmo_d;
        end
    end

    assign A_Data_Out   = a_dout_q;
    assign A_MFC        = a_mfc_q;
    assign A_ANA_FLAG   = a_ana_q;
    assign B_Data_Out   = b_dout_q;
    assign B_MFC        = b_mfc_q;
    assign B_ANA_FLAG   = b_ana_q;
    assign MEM_Address  = mem_addr_q;
    assign MEM_Data_In  = mem_wdata_q;
    assign MEM_Read     = mem_rd_q;
    assign MEM_Write    = mem_wr_q;
    assign Grant        = grant_q;
    assign Timeout_Flag = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a scoreboard
// of expected completions checked whenever a port's MFC pulses.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] A_Address = '0, B_Address = '0;
    logic [DW-1:0] A_Data_In = '0, B_Data_In = '0;
    logic          A_Read = 1'b0, A_Write = 1'b0, B_Read = 1'b0, B_Write = 1'b0;
    logic [DW-1:0] A_Data_Out, B_Data_Out;
    logic          A_MFC, A_ANA_FLAG, B_MFC, B_ANA_FLAG;
    logic [AW-1:0] MEM_Address;
    logic [DW-1:0] MEM_Data_In;
    logic          MEM_Read, MEM_Write;
    logic [DW-1:0] MEM_Data_Out = '0;
    logic          MEM_MFC = 1'b0;
    logic          MEM_ANA_FLAG = 1'b0;
    logic [1:0]    Grant;
    logic          Timeout_Flag;

    always #5 Clock = ~Clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset),
        .A_Address(A_Address), .A_Data_In(A_Data_In), .A_Read(A_Read), .A_Write(A_Write),
        .A_Data_Out(A_Data_Out), .A_MFC(A_MFC), .A_ANA_FLAG(A_ANA_FLAG),
        .B_Address(B_Address), .B_Data_In(B_Data_In), .B_Read(B_Read), .B_Write(B_Write),
        .B_Data_Out(B_Data_Out), .B_MFC(B_MFC), .B_ANA_FLAG(B_ANA_FLAG),
        .MEM_Address(MEM_Address), .MEM_Data_In(MEM_Data_In),
        .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
        .MEM_Data_Out(MEM_Data_Out), .MEM_MFC(MEM_MFC), .MEM_ANA_FLAG(MEM_ANA_FLAG),
        .Grant(Grant), .Timeout_Flag(Timeout_Flag)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        ana;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] mdl_a_data = '0, mdl_b_data = '0;
    logic        mdl_a_ana = 1'b0, mdl_b_ana = 1'b0;
    logic        a_prev = 1'b0, b_prev = 1'b0;

    // Memory behaviour knobs, set by the directed sequence.
    int          mem_lat   = 1;
    logic        mem_hang  = 1'b0;
    logic        mem_ana   = 1'b0;
    logic        use_fixed = 1'b0;
    logic [31:0] mem_fixed = '0;
    int          mem_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: raises MFC mem_lat+1 edges after seeing a strobe, drops it with the strobe.
    always @(posedge Clock) begin
        if (Reset || !(MEM_Read || MEM_Write) || mem_hang) begin
            mem_cnt      <= 0;
            MEM_MFC      <= 1'b0;
            MEM_ANA_FLAG <= 1'b0;
        end else begin
            if (mem_cnt >= mem_lat) begin
                MEM_MFC      <= 1'b1;
                MEM_Data_Out <= use_fixed ? mem_fixed : (MEM_Address ^ 32'h5A5A_0000);
                MEM_ANA_FLAG <= mem_ana;
            end
            mem_cnt <= mem_cnt + 1;
        end
    end

    // Scoreboard monitor: every MFC pulse pops one expected completion.
    always @(negedge Clock) begin
        if (A_MFC) check("a_mfc_one_cycle", a_prev, 0);
        if (B_MFC) check("b_mfc_one_cycle", b_prev, 0);
        if (A_MFC || B_MFC) begin
            check("mfc_both_ports", A_MFC && B_MFC, 0);
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("completion_port", B_MFC, e.port);
                if (B_MFC) begin
                    check("b_data_out", B_Data_Out, e.data);
                    check("b_ana_flag", B_ANA_FLAG, e.ana);
                    mdl_b_data = e.data;
                    mdl_b_ana  = e.ana;
                    check("a_data_untouched", A_Data_Out, mdl_a_data);
                    check("a_ana_untouched", A_ANA_FLAG, mdl_a_ana);
                end else begin
                    check("a_data_out", A_Data_Out, e.data);
                    check("a_ana_flag", A_ANA_FLAG, e.ana);
                    mdl_a_data = e.data;
                    mdl_a_ana  = e.ana;
                    check("b_data_untouched", B_Data_Out, mdl_b_data);
                    check("b_ana_untouched", B_ANA_FLAG, mdl_b_ana);
                end
            end
        end
        a_prev <= A_MFC;
        b_prev <= B_MFC;
    end

    task automatic drop_req(input logic p);
        if (p) begin B_Read = 1'b0; B_Write = 1'b0; end
        else   begin A_Read = 1'b0; A_Write = 1'b0; end
    endtask

    task automatic wait_port(input logic p);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clock);
            if (p ? B_MFC : A_MFC) seen = 1'b1;
        end
        check(p ? "b_mfc_seen" : "a_mfc_seen", seen, 1);
        @(posedge Clock);
        #1;
        drop_req(p);
    endtask

    task automatic idle_gap();
        repeat (2) @(posedge Clock);
        #1;
    endtask

    // Single-port transaction with the arbiter idle; checks the memory side after the grant edge.
    task automatic run_txn(input logic p, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic ana,
                           input logic [31:0] rdata);
        exp_t e;
        idle_gap();
        mem_lat   = lat;
        mem_ana   = ana;
        mem_hang  = 1'b0;
        use_fixed = 1'b1;
        mem_fixed = rdata;
        e.port = p;
        e.ana  = ana;
        e.data = wr ? (p ? mdl_b_data : mdl_a_data) : rdata;
        sb.push_back(e);
        if (p) begin B_Address = addr; B_Data_In = wdata; B_Read = rd; B_Write = wr; end
        else   begin A_Address = addr; A_Data_In = wdata; A_Read = rd; A_Write = wr; end
        @(posedge Clock);
        @(negedge Clock);
        check("grant_access", Grant, p ? 2'b10 : 2'b01);
        check("mem_read", MEM_Read, rd && !wr);
        check("mem_write", MEM_Write, wr);
        check("mem_address", MEM_Address, addr);
        if (wr) check("mem_data_in", MEM_Data_In, wdata);
        wait_port(p);
    endtask

    // Both ports request on the same cycle; first_a says who must win.
    task automatic run_pair(input logic first_a, input logic [31:0] aa, input logic [31:0] ba);
        exp_t ea, eb;
        idle_gap();
        mem_lat   = 1;
        mem_ana   = 1'b0;
        mem_hang  = 1'b0;
        use_fixed = 1'b0;
        ea = '{port: 1'b0, data: aa ^ 32'h5A5A_0000, ana: 1'b0};
        eb = '{port: 1'b1, data: ba ^ 32'h5A5A_0000, ana: 1'b0};
        if (first_a) begin sb.push_back(ea); sb.push_back(eb); end
        else         begin sb.push_back(eb); sb.push_back(ea); end
        A_Address = aa; A_Read = 1'b1;
        B_Address = ba; B_Read = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("tie_grant", Grant, first_a ? 2'b01 : 2'b10);
        fork
            wait_port(1'b0);
            wait_port(1'b1);
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   strobe_cnt;
        bit   seen;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_grant", Grant, 0);
        check("rst_mem_read", MEM_Read, 0);
        check("rst_mem_write", MEM_Write, 0);
        check("rst_mem_addr", MEM_Address, 0);
        check("rst_a_out", {A_MFC, A_ANA_FLAG, B_MFC, B_ANA_FLAG, Timeout_Flag}, 0);
        check("rst_a_data", A_Data_Out, 0);
        check("rst_b_data", B_Data_Out, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Ties right after reset: A first, twice
        run_pair(1'b1, 32'h20, 32'h30);
        run_pair(1'b1, 32'h24, 32'h34);

        // Single A read, memory answers with 0x12345678
        run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h1234_5678);

        // After A won alone, a tie goes to B
        run_pair(1'b0, 32'h28, 32'h38);

        // B write with memory reporting address-not-assigned
        run_txn(1'b1, 1'b0, 1'b1, 32'h3FF, 32'hCAFE_F00D, 1, 1'b1, 32'hDEAD_DEAD);

        // A raises Read and Write together: write wins
        run_txn(1'b0, 1'b1, 1'b1, 32'h8, 32'h5, 1, 1'b0, 32'hBEEF_0001);

        // Timeout with MEM_MFC stuck low
        idle_gap();
        check("tmo_clear_before", Timeout_Flag, 0);
        mem_hang = 1'b1;
        e = '{port: 1'b0, data: 32'h0, ana: 1'b1};
        sb.push_back(e);
        A_Address = 32'h77; A_Read = 1'b1;
        strobe_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clock);
            if (MEM_Read) strobe_cnt++;
            else if (A_MFC) seen = 1'b1;
        end
        check("tmo_mfc_seen", seen, 1);
        check("tmo_strobe_cycles", strobe_cnt, TMO);
        check("tmo_flag_set", Timeout_Flag, 1);
        @(posedge Clock);
        #1;
        drop_req(1'b0);

        // Reset in the 2nd ACCESS cycle, request held through it
        idle_gap();
        A_Address = 32'h44; A_Read = 1'b1;
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        check("tmo_flag_sticky", Timeout_Flag, 1);
        check("rst_mid_read_high", MEM_Read, 1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        mdl_a_data = '0; mdl_a_ana = 1'b0;
        mdl_b_data = '0; mdl_b_ana = 1'b0;
        @(negedge Clock);
        check("rst_mid_mem_read", MEM_Read, 0);
        check("rst_mid_grant", Grant, 0);
        check("rst_mid_a_mfc", A_MFC, 0);
        check("rst_mid_tmo", Timeout_Flag, 0);
        check("rst_mid_a_ana", A_ANA_FLAG, 0);
        mem_hang  = 1'b0;
        mem_lat   = 1;
        mem_ana   = 1'b0;
        use_fixed = 1'b1;
        mem_fixed = 32'h0BAD_BEEF;
        e = '{port: 1'b0, data: 32'h0BAD_BEEF, ana: 1'b0};
        sb.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        check("regrant_grant", Grant, 2'b01);
        check("regrant_read", MEM_Read, 1);
        check("regrant_addr", MEM_Address, 32'h44);
        wait_port(1'b0);

        repeat (5) @(posedge Clock);
        @(negedge Clock);
        check("sb_drained", sb.size(), 0);
        check("end_grant_idle", Grant, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single word-addressable MemoryInterface between the Processor (port A) and a debug/loader master (port B).
- Each port sees the same Read/Write/MFC/ANA_FLAG handshake the memory itself presents.
- The arbiter serialises accesses with round-robin fairness.
- It enforces a release phase between transactions and terminates hung accesses with a timeout.
- It sits between the requesters and MemoryInterface in the top level.

Parameters:
ADDR_W, 32, address width (word address)
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, cycles allowed in ACCESS without MEM_MFC before forced completion (minimum 1)

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
A_Address  in  ADDR_W  port A address
A_Data_In  in  DATA_W  port A write data
A_Read  in  1  port A read request, held until A_MFC
A_Write  in  1  port A write request, held until A_MFC
A_Data_Out  out  DATA_W  port A read data, registered
A_MFC  out  1  port A one-cycle completion pulse
A_ANA_FLAG  out  1  port A address-not-assigned / error flag
B_Address, B_Data_In, B_Read, B_Write  in  ADDR_W/DATA_W/1/1  port B requests, same rules as port A
B_Data_Out, B_MFC, B_ANA_FLAG  out  DATA_W/1/1  port B responses, same rules as port A
MEM_Address  out  ADDR_W  to MemoryInterface, registered
MEM_Data_In  out  DATA_W  to MemoryInterface, registered
MEM_Read  out  1  memory read strobe
MEM_Write  out  1  memory write strobe
MEM_Data_Out  in  DATA_W  memory read data
MEM_MFC  in  1  memory function complete (level)
MEM_ANA_FLAG  in  1  memory address-not-assigned
Grant  out  2  one-hot current owner: 01 = A, 10 = B, 00 = idle
Timeout_Flag  out  1  sticky; set on any timeout, cleared only by Reset

Behaviour:
- Reset state: every output 0, FSM = IDLE, last_grant = B (so A wins the first tie), timeout counter = 0.
- Reset during any state returns the FSM to IDLE on the same edge. Strobes go low and no MFC pulse is issued for the aborted access.

States: IDLE -> ACCESS -> RESP -> RELEASE -> IDLE.
- IDLE:
  - A port is requesting when Read | Write = 1.
  - If one port requests, grant it. If both request, grant the port that is not last_grant.
  - On the granting edge: latch address and data into MEM_Address/MEM_Data_In, set Grant, update last_grant, assert MEM_Write if the port's Write = 1, else MEM_Read. If Read and Write are both 1, write wins.
  - Enter ACCESS. Strobes are therefore asserted 1 cycle after the request is first sampled.
- ACCESS:
  - Hold strobes, address and data stable; the counter increments each cycle.
  - On MEM_MFC = 1: capture MEM_Data_Out (reads only; writes leave Data_Out unchanged) and MEM_ANA_FLAG into the grantee's output registers, drop strobes, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES first: drop strobes, grantee Data_Out = 0, grantee ANA_FLAG = 1, set Timeout_Flag, go to RESP.
- RESP: grantee MFC = 1 for exactly this one cycle. Grant is held. Next state is RELEASE.
- RELEASE:
  - Grant = 00, strobes low, counter cleared.
  - Stay until MEM_MFC = 0, then go to IDLE. The minimum is 1 cycle, which gives the requester time to drop its request.
- Timing: best-case turnaround is 4 cycles plus the memory latency. Back-to-back ties alternate A, B, A, ...
- ANA_FLAG and Data_Out of each port hold their value until that port's next completion. The non-granted port's outputs never change.
- A request asserted or changed while the other port is granted is sampled only in IDLE. Address/data changes during ACCESS are ignored because they are latched.
- Requester rule: a requester must drop Read/Write within 1 cycle of seeing its MFC. A request still high in IDLE is treated as a new transaction.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE, ACCESS, RESP, RELEASE)
  - port IDs PORT_A/PORT_B
  - Grant encodings
  - default TIMEOUT_CYCLES
- One natural sub-module, mem_arb_rr2: a combinational 2-way round-robin pick from (reqA, reqB, last_grant) that returns a one-hot grant. The top-level block holds the FSM, counter and datapath registers.

Test Plan:
1. A_Read, A_Address = 0x10. Memory returns MFC 3 cycles later with data 0x12345678. Required: A_Data_Out = 0x12345678, A_MFC high for exactly 1 cycle, A_ANA_FLAG = 0, B outputs unchanged, Grant = 01 during ACCESS.
2. A_Read and B_Read asserted together right after Reset. Required: A is served first, then B. A second simultaneous pair is served A first again (last_grant = B), and requests alternate thereafter.
3. B_Write, B_Address = 0x3FF, B_Data_In = 0xCAFEF00D, memory returns MFC with MEM_ANA_FLAG = 1. Required: MEM_Write = 1, MEM_Data_In = 0xCAFEF00D, B_ANA_FLAG = 1, B_Data_Out unchanged.
4. A_Read with MEM_MFC held at 0 and TIMEOUT_CYCLES = 8. Required: strobes drop after 8 ACCESS cycles, A_MFC pulses, A_Data_Out = 0, A_ANA_FLAG = 1, Timeout_Flag = 1 until Reset.
5. Reset asserted in the 2nd ACCESS cycle. Required: at the next edge MEM_Read = 0, Grant = 00, no A_MFC pulse. The request is still held after Reset releases, so it is re-granted.
6. A asserts Read and Write together with A_Data_In = 0x5. Required: only MEM_Write is asserted, and MEM_Data_In = 0x5.
